mips_run_ctrl: RTL and testbench

Parametrised run-control and debug-probe block between the board clock/PLL lock and the pipelined MIPS core. It generates the core reset and a clock enable with four modes: free-run, single-step, N-step, and halt. It also supports a PC breakpoint and a registered N-channel probe mux that drives the display/debug bus. It replaces the fixed lock-OR-reset wiring and the fixed debug select used on earlier top levels.

---
 rtl/mips_dbg_pkg.sv | 25 ++
 rtl/mips_run_ctrl_sync_edge.sv | 52 +++++
 rtl/mips_run_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS run-control block.
// Holds the run-control FSM state type with its fixed encodings, the
// iMode constants, and a helper that says which states enable the core
// clock. Imported by mips_run_ctrl.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HALT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_COUNT = 3'd4
  } state_e;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  // Core clock enable is asserted only in the states that execute instructions.
  function automatic logic is_enabled(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level input, with
// an optional rising-edge pulse taken after the synchroniser.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset, clears the whole chain
//   d_i     asynchronous input level
//   level_o synchronised level (two flops after d_i)
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//           (tied to 0 when EDGE_EN is 0)
module sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0] sync_q;

  // Two-stage metastability chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign level_o = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Previous synchronised level for rising-edge detection.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= sync_q[1];
        end
      end

      assign rise_o = sync_q[1] & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run control and debug probe for the pipelined MIPS core.
// Generates the core reset (held until PLL lock has been stable for
// LOCK_HOLD cycles) and a core clock enable with RUN / STEP / COUNT / HALT
// modes, a PC breakpoint with a sticky hit flag, and a registered probe mux.
// Ports:
//   iCLK, iRST          clock, asynchronous active-low reset
//   iLocked             PLL lock (asynchronous, synchronised inside)
//   iMode               00 RUN, 01 STEP, 10 COUNT, 11 HALT
//   iStepReq            step button level (synchronised, rising edge used)
//   iStepCount          number of enabled cycles for COUNT
//   iBreakEn, iBreakPC  breakpoint enable and address, compared with iPC
//   iProbe, iProbeSel   NCH packed channels and channel select
//   oCpuRst, oCpuEn     core reset (high in HOLD) and core clock enable
//   oState              FSM state encoding
//   oStepsLeft          remaining COUNT cycles
//   oBreakHit           sticky breakpoint flag
//   oProbe              selected probe channel, one cycle late
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned NCH       = 8,
  parameter int unsigned LOCK_HOLD = 16,
  parameter int unsigned STEP_W    = 16
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iLocked,
  input  logic [1:0]              iMode,
  input  logic                    iStepReq,
  input  logic [STEP_W-1:0]       iStepCount,
  input  logic                    iBreakEn,
  input  logic [DW-1:0]           iBreakPC,
  input  logic [DW-1:0]           iPC,
  input  logic [NCH*DW-1:0]       iProbe,
  input  logic [$clog2(NCH)-1:0]  iProbeSel,
  output logic                    oCpuRst,
  output logic                    oCpuEn,
  output logic [2:0]              oState,
  output logic [STEP_W-1:0]       oStepsLeft,
  output logic                    oBreakHit,
  output logic [DW-1:0]           oProbe
);

  localparam int unsigned SELW = $clog2(NCH);
  localparam int unsigned HW   = $clog2(LOCK_HOLD + 1);

  logic              lock_s;
  logic              step_rise_s;
  logic              unused_lock_rise_s;
  logic              unused_step_level_s;
  logic              bp_s;

  state_e            state_q, state_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              hit_q, hit_d;
  logic              supp_q, supp_d;
  logic              cpu_en_q, cpu_rst_q;
  logic [DW-1:0]     probe_q, probe_d;

  sync_edge #(.EDGE_EN(1'b0)) u_sync_lock (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .d_i     (iLocked),
    .level_o (lock_s),
    .rise_o  (unused_lock_rise_s)
  );

  sync_edge #(.EDGE_EN(1'b1)) u_sync_step (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .d_i     (iStepReq),
    .level_o (unused_step_level_s),
    .rise_o  (step_rise_s)
  );

  // Breakpoint compare; only meaningful in enabled states. The suppress flag
  // masks the first enabled cycle after HALT so a halted PC can be resumed.
  assign bp_s = iBreakEn && (iPC == iBreakPC) && !supp_q;

  // Next-state logic for the run-control FSM, counters and sticky flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    steps_d = steps_q;
    hit_d   = hit_q;
    if (!lock_s) begin
      // Lock loss wins over everything: back to reset, COUNT progress dropped.
      state_d = ST_HOLD;
      steps_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HW'(LOCK_HOLD - 1)) begin
            state_d = (iMode == MODE_RUN) ? ST_RUN : ST_HALT;
          end else begin
            cnt_d = cnt_q + HW'(1);
          end
        end
        ST_RUN: begin
          if (bp_s) begin
            state_d = ST_HALT;
            hit_d   = 1'b1;
          end else if (iMode == MODE_HALT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          if (step_rise_s) begin
            case (iMode)
              MODE_RUN: begin
                state_d = ST_RUN;
                hit_d   = 1'b0;
              end
              MODE_STEP: begin
                state_d = ST_STEP;
                hit_d   = 1'b0;
              end
              MODE_COUNT: begin
                if (iStepCount != '0) begin
                  state_d = ST_COUNT;
                  steps_d = iStepCount;
                  hit_d   = 1'b0;
                end else begin
                  state_d = ST_HALT;
                end
              end
              default: state_d = ST_HALT;
            endcase
          end else begin
            state_d = ST_HALT;
          end
        end
        ST_STEP: begin
          state_d = ST_HALT;
          if (bp_s) begin
            hit_d = 1'b1;
          end else begin
            hit_d = hit_q;
          end
        end
        ST_COUNT: begin
          if (steps_q == STEP_W'(1)) begin
            // Final cycle of the count completes normally.
            state_d = ST_HALT;
            steps_d = '0;
            if (bp_s) begin
              hit_d = 1'b1;
            end else begin
              hit_d = hit_q;
            end
          end else if (bp_s) begin
            state_d = ST_HALT;
            hit_d   = 1'b1;
          end else if (iMode == MODE_HALT) begin
            state_d = ST_HALT;
          end else begin
            steps_d = steps_q - STEP_W'(1);
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
    supp_d = (state_q == ST_HALT) && is_enabled(state_d);
  end

  // Probe mux; an out-of-range select yields zero.
  always_comb begin
    probe_d = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      probe_d = (iProbeSel == SELW'(k)) ? iProbe[k*DW +: DW] : probe_d;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      steps_q   <= '0;
      hit_q     <= 1'b0;
      supp_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
      cpu_rst_q <= 1'b1;
      probe_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      hit_q     <= hit_d;
      supp_q    <= supp_d;
      cpu_en_q  <= is_enabled(state_d);
      cpu_rst_q <= (state_d == ST_HOLD);
      probe_q   <= probe_d;
    end
  end

  assign oCpuRst    = cpu_rst_q;
  assign oCpuEn     = cpu_en_q;
  assign oState     = state_q;
  assign oStepsLeft = steps_q;
  assign oBreakHit  = hit_q;
  assign oProbe     = probe_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

  localparam int DW = 32, NCH = 8, LOCK_HOLD = 16, STEP_W = 16, SELW = 3;
  localparam logic [2:0] S_HOLD = 3'd0, S_RUN = 3'd1, S_HALT = 3'd2, S_STEP = 3'd3, S_COUNT = 3'd4;
  localparam logic [1:0] M_RUN = 2'b00, M_STEP = 2'b01, M_COUNT = 2'b10, M_HALT = 2'b11;

  logic iCLK, iRST, iLocked, iStepReq, iBreakEn;
  logic [1:0] iMode;
  logic [STEP_W-1:0] iStepCount;
  logic [DW-1:0] iBreakPC, iPC;
  logic [NCH*DW-1:0] iProbe;
  logic [SELW-1:0] iProbeSel;
  logic oCpuRst, oCpuEn, oBreakHit;
  logic [2:0] oState;
  logic [STEP_W-1:0] oStepsLeft;
  logic [DW-1:0] oProbe;

  int errors = 0;
  int checks = 0;
  int en_pulses, en_double;
  logic en_prev;
  logic [DW-1:0] chan [NCH];

  mips_run_ctrl #(.DW(DW), .NCH(NCH), .LOCK_HOLD(LOCK_HOLD), .STEP_W(STEP_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iLocked(iLocked), .iMode(iMode), .iStepReq(iStepReq),
    .iStepCount(iStepCount), .iBreakEn(iBreakEn), .iBreakPC(iBreakPC), .iPC(iPC),
    .iProbe(iProbe), .iProbeSel(iProbeSel), .oCpuRst(oCpuRst), .oCpuEn(oCpuEn),
    .oState(oState), .oStepsLeft(oStepsLeft), .oBreakHit(oBreakHit), .oProbe(oProbe)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Tick and record enable pulses: count high samples and back-to-back highs.
  task automatic tick_rec();
    tick();
    if (oCpuEn === 1'b1) begin
      en_pulses++;
      if (en_prev === 1'b1) en_double++;
    end
    en_prev = oCpuEn;
  endtask

  task automatic pack_probe();
    for (int k = 0; k < NCH; k++) iProbe[k*DW +: DW] = chan[k];
  endtask

  task automatic test_reset();
    for (int k = 0; k < NCH; k++) chan[k] = 32'hDEAD_0000 + k;
    pack_probe();
    iProbeSel = 3'd2;
    iRST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({oCpuRst, oCpuEn, oState, oStepsLeft, oBreakHit} !== {1'b1, 1'b0, S_HOLD, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got rst=%b en=%b st=%0d steps=%0d hit=%b expected rst=1 en=0 st=0 steps=0 hit=0",
               oCpuRst, oCpuEn, oState, oStepsLeft, oBreakHit);
    end
    checks++;
    if (oProbe !== 32'd0) begin
      errors++;
      $display("FAIL reset_probe: got %h expected 0", oProbe);
    end
  endtask

  task automatic test_lock();
    int n;
    iRST = 1'b1;
    repeat (5) tick();
    iLocked = 1'b1;
    repeat (12) tick();
    iLocked = 1'b0;
    repeat (5) tick();
    checks++;
    if ({oCpuRst, oState} !== {1'b1, S_HOLD}) begin
      errors++;
      $display("FAIL lock_restart_hold: got rst=%b st=%0d expected rst=1 st=0", oCpuRst, oState);
    end
    iLocked = 1'b1;
    n = 0;
    while (oCpuRst === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 + LOCK_HOLD) begin
      errors++;
      $display("FAIL lock_release_edges: got %0d expected %0d", n, 2 + LOCK_HOLD);
    end
    checks++;
    if ({oState, oCpuEn} !== {S_RUN, 1'b1}) begin
      errors++;
      $display("FAIL lock_run: got st=%0d en=%b expected st=1 en=1", oState, oCpuEn);
    end
  endtask

  task automatic test_break();
    int n;
    iBreakPC = 32'h40;
    iPC = 32'h20;
    iBreakEn = 1'b1;
    n = 0;
    while (oState === S_RUN && n < 50) begin
      tick();
      n++;
      if (oState === S_RUN) iPC = iPC + 32'd4;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL break_latency: got %0d edges expected 9", n);
    end
    checks++;
    if ({oState, oBreakHit, oCpuEn} !== {S_HALT, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL break_halt: got st=%0d hit=%b en=%b expected st=2 hit=1 en=0", oState, oBreakHit, oCpuEn);
    end
    iMode = M_RUN;
    iStepReq = 1'b1;
    repeat (3) tick();
    iStepReq = 1'b0;
    checks++;
    if ({oState, oBreakHit} !== {S_RUN, 1'b0}) begin
      errors++;
      $display("FAIL break_resume: got st=%0d hit=%b expected st=1 hit=0", oState, oBreakHit);
    end
    tick();
    checks++;
    if ({oState, oBreakHit} !== {S_RUN, 1'b0}) begin
      errors++;
      $display("FAIL break_suppress: got st=%0d hit=%b expected st=1 hit=0", oState, oBreakHit);
    end
    iPC = 32'h44;
    iMode = M_HALT;
    tick();
    checks++;
    if ({oState, oBreakHit, oCpuEn} !== {S_HALT, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL break_mode_halt: got st=%0d hit=%b en=%b expected st=2 hit=0 en=0", oState, oBreakHit, oCpuEn);
    end
    iBreakEn = 1'b0;
  endtask

  task automatic test_step();
    iMode = M_STEP;
    en_pulses = 0; en_double = 0; en_prev = 1'b0;
    for (int p = 0; p < 3; p++) begin
      iStepReq = 1'b1;
      repeat (4) tick_rec();
      iStepReq = 1'b0;
      repeat (4) tick_rec();
    end
    checks++;
    if (en_pulses != 3 || en_double != 0) begin
      errors++;
      $display("FAIL step_three_presses: got pulses=%0d double=%0d expected pulses=3 double=0", en_pulses, en_double);
    end
    en_pulses = 0; en_double = 0;
    iStepReq = 1'b1;
    repeat (100) tick_rec();
    iStepReq = 1'b0;
    repeat (5) tick_rec();
    checks++;
    if (en_pulses != 1 || oState !== S_HALT) begin
      errors++;
      $display("FAIL step_held_press: got pulses=%0d st=%0d expected pulses=1 st=2", en_pulses, oState);
    end
  endtask

  task automatic test_count();
    int nlist [3];
    int en_cnt;
    logic [STEP_W-1:0] exp_steps;
    nlist[0] = 5;
    nlist[1] = $urandom_range(1, 20);
    nlist[2] = $urandom_range(1, 20);
    iMode = M_COUNT;
    for (int t = 0; t < 3; t++) begin
      iStepCount = STEP_W'(nlist[t]);
      exp_steps = STEP_W'(nlist[t]);
      en_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (i == 0) iStepReq = 1'b1;
        if (i == 3) iStepReq = 1'b0;
        tick();
        if (oCpuEn === 1'b1) begin
          checks++;
          if (oStepsLeft !== exp_steps) begin
            errors++;
            $display("FAIL count_steps_left: got %0d expected %0d", oStepsLeft, exp_steps);
          end
          exp_steps = exp_steps - 16'd1;
          en_cnt++;
        end
      end
      checks++;
      if (en_cnt != nlist[t] || {oState, oStepsLeft} !== {S_HALT, 16'd0}) begin
        errors++;
        $display("FAIL count_total: got en=%0d st=%0d steps=%0d expected en=%0d st=2 steps=0",
                 en_cnt, oState, oStepsLeft, nlist[t]);
      end
    end
  endtask

  task automatic test_count_edge();
    int n;
    iMode = M_COUNT;
    iStepCount = 16'd0;
    en_pulses = 0; en_double = 0; en_prev = 1'b0;
    iStepReq = 1'b1;
    repeat (3) tick_rec();
    iStepReq = 1'b0;
    repeat (5) tick_rec();
    checks++;
    if (en_pulses != 0 || {oState, oStepsLeft} !== {S_HALT, 16'd0}) begin
      errors++;
      $display("FAIL count_zero: got pulses=%0d st=%0d steps=%0d expected pulses=0 st=2 steps=0", en_pulses, oState, oStepsLeft);
    end
    iStepCount = 16'd8;
    iStepReq = 1'b1;
    n = 0;
    while (!(oState === S_COUNT && oStepsLeft === 16'd5) && n < 30) begin
      tick();
      n++;
      if (n == 3) iStepReq = 1'b0;
    end
    iStepReq = 1'b0;
    iMode = M_HALT;
    tick();
    checks++;
    if ({oState, oStepsLeft, oCpuEn} !== {S_HALT, 16'd5, 1'b0}) begin
      errors++;
      $display("FAIL count_abort: got st=%0d steps=%0d en=%b expected st=2 steps=5 en=0", oState, oStepsLeft, oCpuEn);
    end
  endtask

  task automatic test_probe();
    logic [SELW-1:0] sel;
    for (int k = 0; k < NCH; k++) chan[k] = 32'h1000 + k;
    pack_probe();
    for (int k = 0; k < NCH; k++) begin
      iProbeSel = SELW'(k);
      tick();
      checks++;
      if (oProbe !== 32'h1000 + k) begin
        errors++;
        $display("FAIL probe_sweep: sel=%0d got %h expected %h", k, oProbe, 32'h1000 + k);
      end
    end
    repeat (10) begin
      for (int k = 0; k < NCH; k++) chan[k] = $urandom;
      pack_probe();
      sel = SELW'($urandom_range(0, NCH - 1));
      iProbeSel = sel;
      tick();
      checks++;
      if (oProbe !== chan[sel]) begin
        errors++;
        $display("FAIL probe_random: sel=%0d got %h expected %h", sel, oProbe, chan[sel]);
      end
    end
  endtask

  task automatic test_lock_loss();
    iMode = M_COUNT;
    iStepCount = 16'd20;
    iStepReq = 1'b1;
    repeat (3) tick();
    iStepReq = 1'b0;
    checks++;
    if ({oState, oStepsLeft} !== {S_COUNT, 16'd20}) begin
      errors++;
      $display("FAIL lossy_count_start: got st=%0d steps=%0d expected st=4 steps=20", oState, oStepsLeft);
    end
    iLocked = 1'b0;
    repeat (2) tick();
    checks++;
    if (oCpuRst !== 1'b0) begin
      errors++;
      $display("FAIL lock_loss_early: got rst=%b expected 0", oCpuRst);
    end
    tick();
    checks++;
    if ({oCpuRst, oCpuEn, oState, oStepsLeft} !== {1'b1, 1'b0, S_HOLD, 16'd0}) begin
      errors++;
      $display("FAIL lock_loss_hold: got rst=%b en=%b st=%0d steps=%0d expected rst=1 en=0 st=0 steps=0",
               oCpuRst, oCpuEn, oState, oStepsLeft);
    end
    chan[5] = $urandom;
    pack_probe();
    iProbeSel = 3'd5;
    tick();
    checks++;
    if (oProbe !== chan[5]) begin
      errors++;
      $display("FAIL probe_in_hold: got %h expected %h", oProbe, chan[5]);
    end
  endtask

  initial begin
    iRST = 1'b1; iLocked = 1'b0; iMode = M_RUN; iStepReq = 1'b0; iStepCount = 16'd0;
    iBreakEn = 1'b0; iBreakPC = 32'd0; iPC = 32'd0; iProbe = '0; iProbeSel = 3'd0;
    #2;
    test_reset();
    test_lock();
    test_break();
    test_step();
    test_count();
    test_count_edge();
    test_probe();
    test_lock_loss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
